xmr_tap_monitor: RTL and testbench



---
 rtl/xmr_tap_pkg.sv | 19 +
 rtl/xmr_tap_fifo.sv | 57 +++++
 rtl/xmr_tap_monitor.sv | 120 ++++++++++++
 tb/tb_xmr_tap_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/xmr_tap_pkg.sv
// Shared definitions for the XMR tap monitor: parameter defaults,
// the record layout and a helper that derives the record width.
package xmr_tap_pkg;

  localparam int unsigned TS_WIDTH_DEFAULT = 15;
  localparam int unsigned DEPTH_DEFAULT    = 8;
  localparam int unsigned REC_W            = TS_WIDTH_DEFAULT + 1;

  // One transition record: polarity above the timestamp.
  typedef struct packed {
    logic                        pol;
    logic [TS_WIDTH_DEFAULT-1:0] ts;
  } rec_t;

  function automatic int unsigned rec_width(input int unsigned ts_w);
    return ts_w + 1;
  endfunction

endpackage

// File: rtl/xmr_tap_fifo.sv
// Synchronous record FIFO for the tap monitor. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module xmr_tap_fifo
  import xmr_tap_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned W     = REC_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_wr, do_rd;

  // Status flags, accepted operations and next pointer values.
  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    count_o = wr_q - rd_q;
    do_rd   = pop_i && !empty_o;
    do_wr   = push_i && (!full_o || do_rd);
    wr_d    = do_wr ? wr_q + 1'b1 : wr_q;
    rd_d    = do_rd ? rd_q + 1'b1 : rd_q;
    dout_o  = mem_q[rd_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Record storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/xmr_tap_monitor.sv
// Consumer end of a bound tap wire: detects transitions of I, timestamps
// them and queues {polarity, timestamp} records for a valid/ready reader.
// Define XMR_TAP_GLITCH_FILTER_EN to require a new level on two consecutive
// samples before it is accepted.
module xmr_tap_monitor
  import xmr_tap_pkg::*;
#(
  parameter int unsigned TS_WIDTH = TS_WIDTH_DEFAULT,
  parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I,
  input  logic              en,
  input  logic              ovf_clr,
  output logic [TS_WIDTH:0] rec_data,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic              overflow,
  output logic              level
);

  localparam int unsigned RW = rec_width(TS_WIDTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                q_q, q_d;
  logic                primed_q;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                ovf_q, ovf_d;
  logic                edge_det, push, pop, drop;
  logic [TS_WIDTH-1:0] edge_ts;
  logic [RW-1:0]       rec_in;
  logic [RW-1:0]       fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;

`ifdef XMR_TAP_GLITCH_FILTER_EN
  logic                raw_q;
  logic [TS_WIDTH-1:0] ts_hold_q;
`endif

  // Edge detection, push/drop decisions, timestamp and overflow next state.
  always_comb begin
`ifdef XMR_TAP_GLITCH_FILTER_EN
    // Accept a level once it has been seen on two edges; stamp it with the
    // time of the first of those samples.
    edge_det = primed_q && (I == raw_q) && (I != q_q);
    edge_ts  = ts_hold_q;
    q_d      = (!primed_q || (I == raw_q)) ? I : q_q;
`else
    edge_det = primed_q && (I != q_q);
    edge_ts  = ts_q;
    q_d      = I;
`endif
    push   = edge_det && en;
    rec_in = {I, edge_ts};
    pop    = rec_ready && !fifo_empty;
    drop   = push && fifo_full && !pop;
    ts_d   = en ? ts_q + 1'b1 : ts_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Level, baseline, timestamp and sticky overflow registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q      <= 1'b0;
      primed_q <= 1'b0;
      ts_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      primed_q <= 1'b1;
      ts_q     <= ts_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef XMR_TAP_GLITCH_FILTER_EN
  // Raw sample history and the timestamp of that sample.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      raw_q     <= 1'b0;
      ts_hold_q <= '0;
    end else begin
      raw_q     <= I;
      ts_hold_q <= ts_q;
    end
  end
`endif

  xmr_tap_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (rec_in),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Outputs come straight from registers or FIFO storage.
  always_comb begin
    rec_valid = (fifo_count != '0);
    rec_data  = fifo_empty ? '0 : fifo_dout;
    overflow  = ovf_q;
    level     = q_q;
  end

endmodule

// File: tb/tb_xmr_tap_monitor.sv
// Directed bench for xmr_tap_monitor: main instance at default widths plus a
// 4-bit-timestamp, 2-deep instance for the wrap case.
module tb_xmr_tap_monitor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        I = 1'b0, en = 1'b0, ovf_clr = 1'b0, rec_ready = 1'b0;
  logic [15:0] rec_data;
  logic        rec_valid, overflow, level;

  logic        I2 = 1'b0;
  logic        en2 = 1'b1, rdy2 = 1'b1, clr2 = 1'b0;
  logic [4:0]  rec_data2;
  logic        rec_valid2, overflow2, level2;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  xmr_tap_monitor #(.TS_WIDTH(15), .DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .en(en), .ovf_clr(ovf_clr),
    .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .overflow(overflow), .level(level)
  );

  xmr_tap_monitor #(.TS_WIDTH(4), .DEPTH(2)) dut_w (
    .CLK(CLK), .RESET(RESET), .I(I2), .en(en2), .ovf_clr(clr2),
    .rec_data(rec_data2), .rec_valid(rec_valid2), .rec_ready(rdy2),
    .overflow(overflow2), .level(level2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, settle 1 time unit past the edge.
  task automatic tick(input logic i_v, input logic en_v, input logic rdy_v, input logic clr_v);
    I = i_v; en = en_v; rec_ready = rdy_v; ovf_clr = clr_v;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic i_v);
    RESET = 1'b1;
    tick(i_v, 1'b1, 1'b0, 1'b0);
    tick(i_v, 1'b1, 1'b0, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    @(posedge CLK); #1;

    // Baseline: I=1 through reset and 20 armed cycles gives no record.
    do_reset(1'b1);
    check("rst_valid", rec_valid, 0);
    check("rst_data", rec_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_level", level, 0);
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      check("base_novalid", rec_valid, 0);
    end
    check("base_level", level, 1);
    check("base_ovf", overflow, 0);

    // Single rise sampled at timestamp 5 (edge 6 after reset).
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("rise_pre", rec_valid, 0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);               // edge 6
    check("rise_valid", rec_valid, 1);
    check("rise_data", rec_data, 32'h8005);
    tick(1'b1, 1'b1, 1'b1, 1'b0);               // edge 7, popped
    check("rise_once", rec_valid, 0);
    check("rise_level", level, 1);

    // Toggle train at timestamps 10..17 with backpressure, 9th dropped.
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);             // edges 8..10
      check("train_idle", rec_valid, 0);
    end
    for (int k = 0; k < 8; k++) tick(k[0], 1'b1, 1'b0, 1'b0);  // edges 11..18
    check("train_full_ovf", overflow, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);               // edge 19, dropped
    check("train_drop_ovf", overflow, 1);
    check("train_head_kept", rec_data, 32'h000A);
    for (int k = 0; k < 8; k++) begin
      e = ((k % 2) ? 32'h8000 : 32'h0) + 32'(10 + k);
      check("train_drain_valid", rec_valid, 1);
      check("train_drain_data", rec_data, e);
      tick(1'b0, 1'b1, 1'b1, 1'b0);             // edges 20..27
    end
    check("train_empty", rec_valid, 0);
    check("train_ovf_sticky", overflow, 1);

    // Clear, refill at ts 28..35, push+pop while full, then drop with clear.
    tick(1'b0, 1'b1, 1'b0, 1'b1);               // edge 28
    check("clr_ovf", overflow, 0);
    for (int k = 0; k < 8; k++) tick(~k[0], 1'b1, 1'b0, 1'b0); // edges 29..36
    check("full_valid", rec_valid, 1);
    tick(1'b1, 1'b1, 1'b1, 1'b0);               // edge 37, push {1,36} + pop
    check("pushpop_ovf", overflow, 0);
    check("pushpop_head", rec_data, 32'h001D);
    tick(1'b0, 1'b1, 1'b0, 1'b1);               // edge 38, drop with clear
    check("drop_clr_ovf", overflow, 1);
    for (int k = 1; k < 9; k++) begin
      e = (k == 8) ? 32'h8024 : (((k % 2) ? 32'h0 : 32'h8000) + 32'(28 + k));
      check("pp_drain_data", rec_data, e);
      tick(1'b0, 1'b1, 1'b1, 1'b0);             // edges 39..46
    end
    check("pp_empty", rec_valid, 0);

    // Disarmed toggles: no records, counter frozen, no stale edge on re-arm.
    tick(1'b1, 1'b0, 1'b1, 1'b0);               // edge 47
    check("dis_v0", rec_valid, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);               // edge 48
    check("dis_v1", rec_valid, 0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);               // edge 49
    check("dis_v2", rec_valid, 0);
    check("dis_level", level, 1);
    tick(1'b1, 1'b1, 1'b1, 1'b0);               // edge 50, ts 46
    check("rearm_nostale", rec_valid, 0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);               // edge 51, ts 47
    check("rearm_valid", rec_valid, 1);
    check("rearm_data", rec_data, 32'h002F);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("rearm_popped", rec_valid, 0);

    // Timestamp wrap on the 4-bit instance: toggles at 15 then 0.
    I2 = 1'b0;
    do_reset(1'b0);
    for (int k = 0; k < 15; k++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    I2 = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 1'b0);               // edge 16, ts 15
    check("wrap_valid15", rec_valid2, 1);
    check("wrap_data15", rec_data2, 32'h1F);
    I2 = 1'b0;
    tick(1'b0, 1'b1, 1'b1, 1'b0);               // edge 17, ts 0
    check("wrap_valid0", rec_valid2, 1);
    check("wrap_data0", rec_data2, 32'h00);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("wrap_empty", rec_valid2, 0);
    check("wrap_ovf", overflow2, 0);

    // Reset with 3 records queued discards them and redoes the baseline.
    do_reset(1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);               // baseline
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("rq_valid", rec_valid, 1);
    check("rq_head", rec_data, 32'h8001);
    RESET = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("rq_rst_valid", rec_valid, 0);
    check("rq_rst_level", level, 0);
    RESET = 1'b0;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("rq_rebase_novalid", rec_valid, 0);
    check("rq_rebase_level", level, 1);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("rq_rebase_quiet", rec_valid, 0);

`ifdef XMR_TAP_GLITCH_FILTER_EN
    // One-cycle pulse is filtered; two-cycle pulse gives records 2 apart.
    do_reset(1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);               // edge 1 baseline
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);               // edge 4 pulse
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);               // edge 6
    check("filt_glitch", rec_valid, 0);
    check("filt_glitch_level", level, 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);               // edge 7, ts 6
    tick(1'b1, 1'b1, 1'b0, 1'b0);               // edge 8, accepted
    check("filt_level_hi", level, 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);               // edge 9, ts 8
    tick(1'b0, 1'b1, 1'b0, 1'b0);               // edge 10, accepted
    check("filt_rise", rec_data, 32'h8006);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("filt_fall", rec_data, 32'h0008);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("filt_empty", rec_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
